// File: rtl/mcycle_datapath_pkg.sv
// Shared codes and types for the multicycle datapath and its iterative multiplier.
package mcycle_datapath_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCA_A      = 2'b00,
        SRCA_PC     = 2'b01,
        SRCA_ALUOUT = 2'b10,
        SRCA_ZERO   = 2'b11
    } src_a_e;

    typedef enum logic [1:0] {
        SRCB_B    = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10,
        SRCB_ZERO = 2'b11
    } src_b_e;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_DATA      = 2'b01,
        RES_ALURESULT = 2'b10,
        RES_MULLO     = 2'b11
    } result_src_e;

    typedef enum logic [1:0] {
        IMM_BYTE   = 2'b00,
        IMM_12     = 2'b01,
        IMM_BRANCH = 2'b10,
        IMM_ZERO   = 2'b11
    } imm_src_e;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_RUN  = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

    localparam int unsigned CONST_FOUR = 4;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low WIDTH bits of the product.
module mul_iter
    import mcycle_datapath_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] product,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    mul_state_e       state;
    mul_state_e       state_next;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_step;
    logic [CNT_W-1:0] count;

    assign acc_step = mplier[0] ? acc + mcand : acc;

    // NOTE: state registers use <= so every flop samples pre-edge values; = here would chain updates within one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= MUL_IDLE;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            state <= state_next;
            case (state)
                MUL_IDLE: begin
                    if (start) begin
                        mcand  <= a;
                        mplier <= b;
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                MUL_RUN: begin
                    acc    <= acc_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CNT_W'(1);
                    if (count == LAST) product <= acc_step;
                end
                default: ;
            endcase
        end
    end

    // NOTE: every output of this block is given a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            MUL_IDLE: if (start) state_next = MUL_RUN;
            MUL_RUN: begin
                busy = 1'b1;
                if (count == LAST) state_next = MUL_DONE;
            end
            MUL_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = MUL_IDLE;
            end
            default: state_next = MUL_IDLE;
        endcase
    end

endmodule

// File: rtl/mcycle_datapath.sv
// Multicycle processor datapath: PC/IR/Data/A/B/ALUOut registers, register file with PC alias,
// immediate extender, 4-op ALU with NZCV flags and a concurrent iterative multiplier.
module mcycle_datapath
    import mcycle_datapath_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREGS = 16
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] Adr,
    output logic [WIDTH-1:0] WriteData,
    input  logic [WIDTH-1:0] ReadData,
    output logic [31:0]      Instr,
    output logic [3:0]       ALUFlags,
    input  logic             PCWrite,
    input  logic             RegWrite,
    input  logic             IRWrite,
    input  logic             AdrSrc,
    input  logic [1:0]       RegSrc,
    input  logic [1:0]       ALUSrcA,
    input  logic [1:0]       ALUSrcB,
    input  logic [1:0]       ResultSrc,
    input  logic [1:0]       ImmSrc,
    input  logic [1:0]       ALUControl,
    input  logic             MulStart,
    output logic             MulBusy,
    output logic             MulDone
);

    localparam int IDX_W = $clog2(NREGS);
    localparam logic [IDX_W-1:0] PC_IDX = IDX_W'(NREGS - 1);

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] mul_lo;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] ext_imm;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [IDX_W-1:0] ra1;
    logic [IDX_W-1:0] ra2;
    logic [IDX_W-1:0] wa;
    logic [WIDTH-1:0] rf [NREGS];
    alu_op_e          alu_op;
    logic             is_sub;
    alu_flags_t       flags;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= '0;
            Instr   <= '0;
            data    <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            alu_out <= '0;
        end else begin
            if (PCWrite) pc <= result;
            if (IRWrite) Instr <= 32'(ReadData);
            data    <= ReadData;
            a_reg   <= rd1;
            b_reg   <= rd2;
            alu_out <= alu_result;
        end
    end

    // NOTE: the register file has no reset; contents survive reset and software initialises them.
    assign wa = Instr[12 +: IDX_W];
    always_ff @(posedge clk) begin
        if (RegWrite) rf[wa] <= result;
    end

    // The top index aliases the PC: reads of it see the current Result.
    always_comb begin
        ra1 = RegSrc[0] ? PC_IDX : Instr[16 +: IDX_W];
        ra2 = RegSrc[1] ? Instr[12 +: IDX_W] : Instr[0 +: IDX_W];
        rd1 = (ra1 == PC_IDX) ? result : rf[ra1];
        rd2 = (ra2 == PC_IDX) ? result : rf[ra2];
    end

    always_comb begin
        ext_imm = '0;
        case (imm_src_e'(ImmSrc))
            IMM_BYTE:   ext_imm = WIDTH'(Instr[7:0]);
            IMM_12:     ext_imm = WIDTH'(Instr[11:0]);
            IMM_BRANCH: ext_imm = WIDTH'({{WIDTH{Instr[23]}}, Instr[23:0], 2'b00});
            default:    ext_imm = '0;
        endcase
    end

    always_comb begin
        src_a = a_reg;
        case (src_a_e'(ALUSrcA))
            SRCA_A:      src_a = a_reg;
            SRCA_PC:     src_a = pc;
            SRCA_ALUOUT: src_a = alu_out;
            default:     src_a = '0;
        endcase
        src_b = b_reg;
        case (src_b_e'(ALUSrcB))
            SRCB_B:    src_b = b_reg;
            SRCB_IMM:  src_b = ext_imm;
            SRCB_FOUR: src_b = WIDTH'(CONST_FOUR);
            default:   src_b = '0;
        endcase
    end

    // Subtraction is a + ~b + 1, so the adder's carry-out is already NOT borrow.
    assign alu_op = alu_op_e'(ALUControl);
    assign is_sub = (alu_op == ALU_SUB);
    assign b_eff  = is_sub ? ~src_b : src_b;
    assign sum    = {1'b0, src_a} + {1'b0, b_eff} + (WIDTH + 1)'(is_sub);

    always_comb begin
        alu_result = sum[WIDTH-1:0];
        flags      = '0;
        case (alu_op)
            ALU_ADD, ALU_SUB: begin
                alu_result = sum[WIDTH-1:0];
                flags.c    = sum[WIDTH];
                flags.v    = (src_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                             (alu_result[WIDTH-1] != src_a[WIDTH-1]);
            end
            ALU_AND: alu_result = src_a & src_b;
            default: alu_result = src_a | src_b;
        endcase
        flags.n = alu_result[WIDTH-1];
        flags.z = (alu_result == '0);
    end

    assign ALUFlags = flags;

    always_comb begin
        result = alu_out;
        case (result_src_e'(ResultSrc))
            RES_ALUOUT:    result = alu_out;
            RES_DATA:      result = data;
            RES_ALURESULT: result = alu_result;
            default:       result = mul_lo;
        endcase
    end

    assign Adr       = AdrSrc ? result : pc;
    assign WriteData = b_reg;

    mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk    (clk),
        .reset  (reset),
        .start  (MulStart),
        .a      (a_reg),
        .b      (b_reg),
        .product(mul_lo),
        .busy   (MulBusy),
        .done   (MulDone)
    );

endmodule

// File: tb/tb_mcycle_datapath.sv
// Directed bench for mcycle_datapath: a 32-bit/16-register instance and a 16-bit/8-register instance.
module tb_mcycle_datapath;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic [31:0] adr, write_data, read_data, instr;
    logic [3:0]  alu_flags;
    logic        pc_write, reg_write, ir_write, adr_src;
    logic [1:0]  reg_src, alu_src_a, alu_src_b, result_src, imm_src, alu_control;
    logic        mul_start, mul_busy, mul_done;

    logic [15:0] s_adr, s_write_data, s_read_data;
    logic [31:0] s_instr;
    logic [3:0]  s_alu_flags;
    logic        s_pc_write, s_reg_write, s_ir_write, s_adr_src;
    logic [1:0]  s_reg_src, s_alu_src_a, s_alu_src_b, s_result_src, s_imm_src, s_alu_control;
    logic        s_mul_start, s_mul_busy, s_mul_done;

    int n_cmp = 0;
    int n_bad = 0;

    mcycle_datapath #(.WIDTH(32), .NREGS(16)) dut (
        .clk(clk), .reset(reset), .Adr(adr), .WriteData(write_data), .ReadData(read_data),
        .Instr(instr), .ALUFlags(alu_flags), .PCWrite(pc_write), .RegWrite(reg_write),
        .IRWrite(ir_write), .AdrSrc(adr_src), .RegSrc(reg_src), .ALUSrcA(alu_src_a),
        .ALUSrcB(alu_src_b), .ResultSrc(result_src), .ImmSrc(imm_src), .ALUControl(alu_control),
        .MulStart(mul_start), .MulBusy(mul_busy), .MulDone(mul_done)
    );

    mcycle_datapath #(.WIDTH(16), .NREGS(8)) dut16 (
        .clk(clk), .reset(reset), .Adr(s_adr), .WriteData(s_write_data), .ReadData(s_read_data),
        .Instr(s_instr), .ALUFlags(s_alu_flags), .PCWrite(s_pc_write), .RegWrite(s_reg_write),
        .IRWrite(s_ir_write), .AdrSrc(s_adr_src), .RegSrc(s_reg_src), .ALUSrcA(s_alu_src_a),
        .ALUSrcB(s_alu_src_b), .ResultSrc(s_result_src), .ImmSrc(s_imm_src),
        .ALUControl(s_alu_control), .MulStart(s_mul_start), .MulBusy(s_mul_busy),
        .MulDone(s_mul_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Write val into register idx through the Data register and ResultSrc=Data.
    task automatic write_reg(input logic [3:0] idx, input logic [31:0] val);
        read_data = {16'h0, idx, 12'h000};
        ir_write  = 1'b1;
        tick();
        ir_write  = 1'b0;
        read_data = val;
        tick();
        result_src = 2'b01;
        reg_write  = 1'b1;
        tick();
        reg_write  = 1'b0;
    endtask

    task automatic load_operands(input logic [31:0] word);
        read_data = word;
        ir_write  = 1'b1;
        tick();
        ir_write  = 1'b0;
        reg_src   = 2'b00;
        tick();
    endtask

    task automatic run_mul(input int restart_at, input int reset_at, input logic [31:0] prev,
                           output int busy_n, output int done_n, output int done_at);
        busy_n    = 0;
        done_n    = 0;
        done_at   = 0;
        mul_start = 1'b1;
        tick();
        mul_start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (mul_busy) busy_n++;
            if (mul_done) begin
                done_n++;
                if (done_at == 0) done_at = c;
            end
            if (c == 3) check("mul_prev_product", adr, prev);
            mul_start = (c == restart_at);
            reset     = (c == reset_at);
            tick();
        end
        mul_start = 1'b0;
        reset     = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_n, done_n, done_at;
        reset = 1'b1;
        {pc_write, reg_write, ir_write, adr_src, mul_start} = '0;
        {reg_src, alu_src_a, alu_src_b, result_src, imm_src, alu_control} = '0;
        read_data = '0;
        {s_pc_write, s_reg_write, s_ir_write, s_adr_src, s_mul_start} = '0;
        {s_reg_src, s_alu_src_a, s_alu_src_b, s_result_src, s_imm_src, s_alu_control} = '0;
        s_read_data = '0;
        tick();
        tick();

        check("rst_adr", adr, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_writedata", write_data, 32'h0);
        check("rst_flags", 32'(alu_flags), 32'h4);
        check("rst_busy", 32'(mul_busy), 32'h0);
        check("rst_done", 32'(mul_done), 32'h0);
        check("rst16_adr", 32'(s_adr), 32'h0);

        // PC <= PC + 4
        reset      = 1'b0;
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        adr_src    = 1'b0;
        pc_write   = 1'b1;
        tick();
        pc_write = 1'b0;
        check("pc_plus4_adr", adr, 32'h4);
        tick();
        check("pc_hold", adr, 32'h4);
        adr_src = 1'b1;
        #1;
        check("adr_result", adr, 32'h8);

        // Immediate formats, observed as PC(4) + ExtImm
        read_data = 32'h0081_2345;
        ir_write  = 1'b1;
        tick();
        ir_write  = 1'b0;
        check("ir_load", instr, 32'h0081_2345);
        alu_src_b = 2'b01;
        imm_src = 2'b00; #1; check("imm_byte", adr, 32'h0000_0049);
        imm_src = 2'b01; #1; check("imm_12", adr, 32'h0000_0349);
        imm_src = 2'b10; #1; check("imm_branch", adr, 32'hFE04_8D18);
        imm_src = 2'b11; #1; check("imm_zero", adr, 32'h0000_0004);

        // ALU on A = r1, B = r2
        write_reg(4'd1, 32'h7FFF_FFFF);
        write_reg(4'd2, 32'h0000_0001);
        load_operands(32'h0001_0002);
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b10;
        alu_control = 2'b00; #1;
        check("add_ovf_result", adr, 32'h8000_0000);
        check("add_ovf_flags", 32'(alu_flags), 32'h9);
        alu_control = 2'b01; #1;
        check("sub_result", adr, 32'h7FFF_FFFE);
        check("sub_flags", 32'(alu_flags), 32'h2);
        alu_control = 2'b10; #1;
        check("and_result", adr, 32'h0000_0001);
        check("and_flags", 32'(alu_flags), 32'h0);
        alu_control = 2'b11; #1;
        check("or_result", adr, 32'h7FFF_FFFF);
        check("writedata_b", write_data, 32'h0000_0001);
        alu_control = 2'b00;
        tick();
        result_src = 2'b00; #1;
        check("aluout_reg", adr, 32'h8000_0000);

        write_reg(4'd1, 32'd5);
        write_reg(4'd2, 32'd5);
        load_operands(32'h0001_0002);
        result_src  = 2'b10;
        alu_control = 2'b01; #1;
        check("sub_eq_result", adr, 32'h0);
        check("sub_eq_flags", 32'(alu_flags), 32'h6);

        // Multiplier: 0x00010003 * 0x00020005 = 0x2_000B_000F
        write_reg(4'd1, 32'h0001_0003);
        write_reg(4'd2, 32'h0002_0005);
        load_operands(32'h0001_0002);
        result_src = 2'b11;
        adr_src    = 1'b1;
        #1;
        run_mul(0, 0, 32'h0, busy_n, done_n, done_at);
        check("mul_busy_cycles", 32'(busy_n), 32'd33);
        check("mul_done_cycle", 32'(done_at), 32'd33);
        check("mul_done_count", 32'(done_n), 32'd1);
        check("mul_lo", adr, 32'h000B_000F);

        run_mul(5, 0, 32'h000B_000F, busy_n, done_n, done_at);
        check("restart_busy_cycles", 32'(busy_n), 32'd33);
        check("restart_done_cycle", 32'(done_at), 32'd33);
        check("restart_done_count", 32'(done_n), 32'd1);
        check("restart_mul_lo", adr, 32'h000B_000F);

        run_mul(0, 10, 32'h000B_000F, busy_n, done_n, done_at);
        check("abort_busy_cycles", 32'(busy_n), 32'd10);
        check("abort_done_count", 32'(done_n), 32'd0);
        check("abort_busy_low", 32'(mul_busy), 32'h0);
        check("abort_mul_lo", adr, 32'h0);

        // Register file survives reset
        load_operands(32'h0001_0002);
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b11;
        alu_control = 2'b00;
        result_src  = 2'b10;
        #1;
        check("rf_kept_after_reset", adr, 32'h0001_0003);

        // 16-bit, 8-register instance
        s_read_data = 16'h3000;
        s_ir_write  = 1'b1;
        tick();
        s_ir_write  = 1'b0;
        s_read_data = 16'hBEEF;
        tick();
        s_result_src = 2'b01;
        s_reg_write  = 1'b1;
        tick();
        s_reg_write = 1'b0;
        s_reg_src   = 2'b10;
        tick();
        check("w16_read_r3", 32'(s_write_data), 32'h0000_BEEF);

        s_read_data = 16'h7000;
        s_ir_write  = 1'b1;
        tick();
        s_ir_write  = 1'b0;
        s_read_data = 16'h1234;
        tick();
        tick();
        check("w16_read_r7_result", 32'(s_write_data), 32'h0000_1234);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
